// File: rtl/obi_data_responder.sv
// OBI data-port responder: word RAM plus exit register, fixed-latency in-order responses.
// Define OBI_RESP_RANDOM_STALL_EN to enable LFSR-driven pseudo-random grant stalls.
module obi_data_responder #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] EXIT_ADDR       = 32'h2000_0004,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [RESP_LATENCY-1:0]        vld_q, vld_d;
  logic [RESP_LATENCY-1:0]        err_q, err_d;
  logic [RESP_LATENCY-1:0][31:0]  rdata_q, rdata_d;
  logic                           exit_valid_q, exit_valid_d;
  logic [31:0]                    exit_value_q, exit_value_d;
  logic [31:0]                    mem_q [DEPTH];

  logic                  stall;
  logic                  accept;
  logic                  is_ram;
  logic                  is_exit;
  logic [ADDR_WIDTH-3:0] idx;

`ifdef OBI_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Taps 16,14,13,11 expressed on a right-shifting register.
  always_comb lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign gnt_o   = rst_ni && (cnt_q < MAX_OUT) && !stall;
  assign accept  = req_i && gnt_o;
  assign is_ram  = (addr_i[31:ADDR_WIDTH] == '0);
  assign is_exit = !is_ram && we_i && ((addr_i & 32'hFFFF_FFFC) == EXIT_ADDR);
  assign idx     = addr_i[ADDR_WIDTH-1:2];

  always_comb begin
    vld_d   = vld_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    for (int unsigned i = RESP_LATENCY - 1; i > 0; i--) begin
      vld_d[i]   = vld_q[i-1];
      err_d[i]   = err_q[i-1];
      rdata_d[i] = rdata_q[i-1];
    end
    // Load data is sampled at the accept edge; the RAM write of an earlier store has already landed.
    vld_d[0]   = accept;
    err_d[0]   = accept && !is_ram && !is_exit;
    rdata_d[0] = (accept && is_ram && !we_i) ? mem_q[idx] : '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, vld_q[RESP_LATENCY-1]})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    exit_valid_d = exit_valid_q;
    exit_value_d = exit_value_q;
    if (accept && is_exit) begin
      exit_valid_d = 1'b1;
      exit_value_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      vld_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      vld_q        <= vld_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && is_ram && we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rvalid_o     = vld_q[RESP_LATENCY-1];
  assign err_o        = err_q[RESP_LATENCY-1];
  assign rdata_o      = rdata_q[RESP_LATENCY-1];
  assign exit_valid_o = exit_valid_q;
  assign exit_value_o = exit_value_q;

endmodule

// File: tb/tb_obi_data_responder.sv
// Self-checking bench for obi_data_responder: transaction-level reference model plus directed pins.
module tb_obi_data_responder;

  localparam int unsigned AW   = 12;
  localparam int unsigned LAT  = 3;
  localparam int unsigned MAXO = 2;
  localparam logic [31:0] EXIT = 32'h2000_0004;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        exit_valid;
  logic [31:0] exit_value;

  obi_data_responder #(
    .ADDR_WIDTH(AW), .RESP_LATENCY(LAT), .MAX_OUTSTANDING(MAXO),
    .EXIT_ADDR(EXIT), .LFSR_SEED(SEED)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .err_o(err), .exit_valid_o(exit_valid), .exit_value_o(exit_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending responses tagged with the edge after which they show.
  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mmem [2**(AW-2)];
  logic        m_exit_v;
  logic [31:0] m_exit_val;
  logic [15:0] m_lfsr;
  int unsigned ek = 0;
  bit          acc_seen = 0;
  int unsigned rv_count = 0;
  int unsigned elig = 0;
  int unsigned stalled = 0;

  function automatic bit m_stall();
`ifdef OBI_RESP_RANDOM_STALL_EN
    return m_lfsr[1:0] == 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_gnt();
    return (q.size() < MAXO) && !m_stall();
  endfunction

  task automatic model_accept();
    resp_t       r;
    int unsigned w;
    r.due   = ek + LAT - 1;
    r.err   = 1'b0;
    r.rdata = 32'h0;
    if (addr < (32'd1 << AW)) begin
      w = addr / 4;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mmem[w][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        r.rdata = mmem[w];
      end
    end else if (we && (addr / 4 == EXIT / 4)) begin
      m_exit_v   = 1'b1;
      m_exit_val = wdata;
    end else begin
      r.err = 1'b1;
    end
    q.push_back(r);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_exit_v   = 1'b0;
      m_exit_val = 32'h0;
      m_lfsr     = SEED;
      acc_seen   = 1'b0;
    end else begin
      bit g;
      g = m_gnt();
      ek++;
      if (q.size() > 0 && q[0].due == ek - 1) void'(q.pop_front());
      acc_seen = req && g;
      if (acc_seen) model_accept();
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", {31'b0, gnt}, 32'd0);
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_exit_valid", {31'b0, exit_valid}, 32'd0);
      chk("rst_exit_value", exit_value, 32'd0);
    end else begin
      bit ev;
      ev = (q.size() > 0) && (q[0].due == ek);
      chk("gnt", {31'b0, gnt}, {31'b0, m_gnt()});
      chk("rvalid", {31'b0, rvalid}, {31'b0, ev});
      if (ev) begin
        chk("rdata", rdata, q[0].rdata);
        chk("err", {31'b0, err}, {31'b0, q[0].err});
      end
      chk("exit_valid", {31'b0, exit_valid}, {31'b0, m_exit_v});
      chk("exit_value", exit_value, m_exit_val);
      if (rvalid) rv_count++;
      if (q.size() < MAXO) begin
        elig++;
        if (!gnt) stalled++;
      end
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (acc_seen) begin
        req = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL accept_timeout actual=no_grant required=grant addr=%h", a);
    req = 1'b0;
  endtask

  task automatic xact(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    rd = 32'h0; er = 1'b0; lat = 0;
    issue(w, a, b, d);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rvalid) begin
        lat = i; rd = rdata; er = err;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout actual=no_rvalid required=rvalid addr=%h", a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int unsigned base;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_reset_gnt", {31'b0, gnt}, 32'd1);
    chk("lit_reset_rvalid", {31'b0, rvalid}, 32'd0);
    chk("lit_reset_exit_valid", {31'b0, exit_valid}, 32'd0);
    chk("lit_reset_exit_value", exit_value, 32'd0);

    xact(1'b1, 32'h10, 4'hF, 32'hCAFE_F00D, rd, er, lat);
    chk("lit_store_err", {31'b0, er}, 32'd0);
    xact(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    chk("lit_load_data", rd, 32'hCAFE_F00D);
    chk("lit_load_err", {31'b0, er}, 32'd0);
    chk("lit_latency", lat, LAT);

    xact(1'b1, 32'h20, 4'hF, 32'h1122_3344, rd, er, lat);
    xact(1'b1, 32'h20, 4'b0101, 32'hAAAA_AAAA, rd, er, lat);
    xact(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
    chk("lit_byte_enable", rd, 32'h11AA_33AA);

    xact(1'b1, 32'h24, 4'h0, 32'hFFFF_FFFF, rd, er, lat);
    chk("lit_be0_err", {31'b0, er}, 32'd0);

    xact(1'b1, EXIT, 4'h0, 32'h0000_002A, rd, er, lat);
    chk("lit_exit_valid", {31'b0, exit_valid}, 32'd1);
    chk("lit_exit_value", exit_value, 32'd42);
    xact(1'b0, 32'h3000_0000, 4'h0, 32'h0, rd, er, lat);
    chk("lit_bad_addr_err", {31'b0, er}, 32'd1);
    chk("lit_bad_addr_rdata", rd, 32'd0);
    xact(1'b0, EXIT, 4'h0, 32'h0, rd, er, lat);
    chk("lit_exit_load_err", {31'b0, er}, 32'd1);

    for (int i = 0; i < 8; i++) issue(1'b1, 32'h40 + 4 * i, 4'hF, 32'h0111_0000 * (i + 1));
    drain();
    base = rv_count;
    for (int i = 0; i < 8; i++) issue(1'b0, 32'h40 + 4 * i, 4'h0, 32'h0);
    drain();
    chk("lit_burst_pulses", rv_count - base, 32'd8);

    issue(1'b0, 32'h10, 4'h0, 32'h0);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = rv_count;
    @(negedge clk);
    chk("lit_gnt_after_reset", {31'b0, gnt}, 32'd1);
    repeat (6) @(negedge clk);
    chk("lit_reset_drops_resp", rv_count - base, 32'd0);
    xact(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    chk("lit_ram_kept", rd, 32'hCAFE_F00D);

    for (int i = 0; i < 16; i++) issue(1'b1, 32'h100 + 4 * i, 4'hF, $urandom);
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] a;
      a = 32'h100 + 4 * $urandom_range(0, 15);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: issue(1'b0, a, 4'h0, 32'h0);
        4, 5, 6:    issue(1'b1, a, 4'($urandom_range(0, 15)), $urandom);
        7:          issue(1'b1, EXIT + 32'($urandom_range(0, 3)), 4'h0, $urandom);
        8:          issue(1'b0, EXIT, 4'h0, 32'h0);
        default:    issue(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) != 0) ? 32'h3000_0000 : 32'h1000 + 4 * $urandom_range(0, 63),
                          4'hF, $urandom);
      endcase
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

`ifdef OBI_RESP_RANDOM_STALL_EN
    checks++;
    if (elig == 0 || stalled * 100 < elig * 20 || stalled * 100 > elig * 30) begin
      errors++;
      $display("FAIL stall_ratio actual=%0d/%0d required=20..30 percent", stalled, elig);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
